// File: rtl/bus_arbiter_if.sv
// Port bundle of the I/D arbiter: both CPU-side master ports plus the
// single system-bus master port. The arbiter uses the master view; the
// environment (CPU ports and bus model) uses the slave view.
interface bus_arbiter_if;
    // instruction-fetch port
    logic        i_req;
    logic        i_write;
    logic        i_size;
    logic [31:0] i_address;
    logic [31:0] i_writedata;
    logic        i_done;
    logic [31:0] i_readdata;
    logic        i_response;
    // data-memory port
    logic        d_req;
    logic        d_write;
    logic        d_size;
    logic [31:0] d_address;
    logic [31:0] d_writedata;
    logic        d_done;
    logic [31:0] d_readdata;
    logic        d_response;
    // system bus
    logic        Hsize;
    logic        Hwrite;
    logic [31:0] Hwritedata;
    logic [31:0] Haddress;
    logic [31:0] Hreaddata;
    logic        Hresponse;
    logic        Hready;

    modport master (
        input  i_req, i_write, i_size, i_address, i_writedata,
        output i_done, i_readdata, i_response,
        input  d_req, d_write, d_size, d_address, d_writedata,
        output d_done, d_readdata, d_response,
        output Hsize, Hwrite, Hwritedata, Haddress,
        input  Hreaddata, Hresponse, Hready
    );

    modport slave (
        output i_req, i_write, i_size, i_address, i_writedata,
        input  i_done, i_readdata, i_response,
        output d_req, d_write, d_size, d_address, d_writedata,
        input  d_done, d_readdata, d_response,
        input  Hsize, Hwrite, Hwritedata, Haddress,
        output Hreaddata, Hresponse, Hready
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master (I-fetch / D-memory) arbiter in front of a single bus master
// port. Fixed D priority with a bounded D streak so I cannot starve, and a
// per-transaction watchdog that aborts with an error response.
module bus_arbiter #(
    parameter int          STREAK_MAX = 4,
    parameter int          TIMEOUT    = 255,
    parameter logic [31:0] IDLE_ADDR  = 32'hFFFF_FFFF
) (
    input  logic          Hclock,
    input  logic          Hreset,
    bus_arbiter_if.master bus
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic OWN_D = 1'b0;
    localparam logic OWN_I = 1'b1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nxt;
    logic          owner;
    logic [2:0]    streak;
    logic [TW-1:0] tcnt;
    logic          any_req;
    logic          grant_i;
    logic          tmo;

    assign any_req = bus.i_req | bus.d_req;
    // I wins when alone, or when D has used up its streak allowance
    assign grant_i = bus.i_req & (~bus.d_req | (streak == 3'(STREAK_MAX)));
    assign tmo     = (tcnt == TW'(TIMEOUT - 1));

    // state register
    always_ff @(posedge Hclock or negedge Hreset) begin
        if (!Hreset) state <= IDLE;
        else         state <= state_nxt;
    end

    // next-state decode; requests are ignored outside IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = BUSY;
            BUSY:    if (bus.Hready || tmo) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // completion pulse to the owning master, one cycle in DONE
    always_comb begin
        bus.i_done = 1'b0;
        bus.d_done = 1'b0;
        if (state == DONE) begin
            bus.i_done = (owner == OWN_I);
            bus.d_done = (owner == OWN_D);
        end
    end

    // grant latch, watchdog, streak and result capture
    always_ff @(posedge Hclock or negedge Hreset) begin
        if (!Hreset) begin
            owner          <= OWN_D;
            streak         <= '0;
            tcnt           <= '0;
            bus.Haddress   <= IDLE_ADDR;
            bus.Hwrite     <= 1'b0;
            bus.Hsize      <= 1'b0;
            bus.Hwritedata <= '0;
            bus.i_readdata <= '0;
            bus.i_response <= 1'b0;
            bus.d_readdata <= '0;
            bus.d_response <= 1'b0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    owner <= grant_i ? OWN_I : OWN_D;
                    tcnt  <= '0;
                    if (grant_i) begin
                        bus.Haddress   <= bus.i_address;
                        bus.Hwrite     <= bus.i_write;
                        bus.Hsize      <= bus.i_size;
                        bus.Hwritedata <= bus.i_writedata;
                        streak         <= '0;
                    end else begin
                        bus.Haddress   <= bus.d_address;
                        bus.Hwrite     <= bus.d_write;
                        bus.Hsize      <= bus.d_size;
                        bus.Hwritedata <= bus.d_writedata;
                        if (!bus.i_req)
                            streak <= '0;
                        else if (streak != 3'(STREAK_MAX))
                            streak <= streak + 3'd1;
                    end
                end
                BUSY: begin
                    // bus ready wins over a coincident timeout
                    if (bus.Hready || tmo) begin
                        if (owner == OWN_I) begin
                            bus.i_readdata <= bus.Hready ? bus.Hreaddata : 32'h0;
                            bus.i_response <= bus.Hready ? bus.Hresponse : 1'b1;
                        end else begin
                            bus.d_readdata <= bus.Hready ? bus.Hreaddata : 32'h0;
                            bus.d_response <= bus.Hready ? bus.Hresponse : 1'b1;
                        end
                        bus.Haddress   <= IDLE_ADDR;
                        bus.Hwrite     <= 1'b0;
                        bus.Hsize      <= 1'b0;
                        bus.Hwritedata <= '0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset values, single read, priority,
// starvation limit, wait states, watchdog timeout and reset mid-transaction.
module tb_bus_arbiter;
    logic Hclock = 1'b0;
    logic Hreset = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    bus_arbiter_if bus_if ();

    bus_arbiter dut (
        .Hclock (Hclock),
        .Hreset (Hreset),
        .bus    (bus_if)
    );

    always #5 Hclock = ~Hclock;

    task automatic tick();
        @(posedge Hclock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic        early;
        logic [31:0] exp_addr;

        bus_if.i_req = 0; bus_if.i_write = 0; bus_if.i_size = 0;
        bus_if.i_address = 0; bus_if.i_writedata = 0;
        bus_if.d_req = 0; bus_if.d_write = 0; bus_if.d_size = 0;
        bus_if.d_address = 0; bus_if.d_writedata = 0;
        bus_if.Hreaddata = 0; bus_if.Hresponse = 0; bus_if.Hready = 0;

        // reset values
        tick(); tick();
        chk("rst_haddr",  bus_if.Haddress, 32'hFFFFFFFF);
        chk("rst_hwrite", bus_if.Hwrite, 0);
        chk("rst_hsize",  bus_if.Hsize, 0);
        chk("rst_hwdata", bus_if.Hwritedata, 0);
        chk("rst_done",   {bus_if.i_done, bus_if.d_done}, 0);
        chk("rst_rdata",  bus_if.i_readdata | bus_if.d_readdata, 0);
        chk("rst_resp",   {bus_if.i_response, bus_if.d_response}, 0);
        Hreset = 1;
        tick();

        // single I read
        bus_if.i_req = 1; bus_if.i_address = 32'h1FC00000;
        tick();
        chk("i1_haddr", bus_if.Haddress, 32'h1FC00000);
        chk("i1_hwrite", bus_if.Hwrite, 0);
        bus_if.i_req = 0; bus_if.Hready = 1; bus_if.Hreaddata = 32'h3C08BFC0;
        tick();
        chk("i1_idone", bus_if.i_done, 1);
        chk("i1_ddone", bus_if.d_done, 0);
        chk("i1_rdata", bus_if.i_readdata, 32'h3C08BFC0);
        chk("i1_resp",  bus_if.i_response, 0);
        chk("i1_haddr_idle", bus_if.Haddress, 32'hFFFFFFFF);
        bus_if.Hready = 0;
        tick();
        chk("i1_idone_end", bus_if.i_done, 0);

        // simultaneous requests: D first, then I
        bus_if.i_req = 1; bus_if.i_address = 32'h1FC00004;
        bus_if.d_req = 1; bus_if.d_address = 32'h00000010;
        tick();
        chk("sim_first_d", bus_if.Haddress, 32'h00000010);
        bus_if.d_req = 0; bus_if.Hready = 1; bus_if.Hreaddata = 32'hAAAA0001;
        tick();
        chk("sim_ddone", bus_if.d_done, 1);
        chk("sim_drdata", bus_if.d_readdata, 32'hAAAA0001);
        chk("sim_irdata_kept", bus_if.i_readdata, 32'h3C08BFC0);
        tick();
        tick();
        chk("sim_then_i", bus_if.Haddress, 32'h1FC00004);
        bus_if.Hreaddata = 32'hAAAA0002;
        tick();
        chk("sim_idone", bus_if.i_done, 1);
        bus_if.i_req = 0; bus_if.Hready = 0;
        tick();

        // starvation: both held, Hready high -> D,D,D,D,I,...
        bus_if.i_req = 1; bus_if.d_req = 1; bus_if.Hready = 1;
        bus_if.Hreaddata = 32'h0BADF00D;
        for (int g = 0; g < 10; g++) begin
            exp_addr = ((g % 5) == 4) ? 32'h1FC00004 : 32'h00000010;
            tick();
            chk($sformatf("starve_grant%0d", g), bus_if.Haddress, exp_addr);
            tick();
            chk($sformatf("starve_done%0d", g), {bus_if.i_done, bus_if.d_done},
                ((g % 5) == 4) ? 32'd2 : 32'd1);
            tick();
        end
        bus_if.i_req = 0; bus_if.d_req = 0; bus_if.Hready = 0;
        tick();

        // wait states: D write, Hready low for 5 BUSY cycles
        bus_if.d_req = 1; bus_if.d_write = 1; bus_if.d_size = 1;
        bus_if.d_address = 32'h20000040; bus_if.d_writedata = 32'hDEADBEEF;
        bus_if.Hresponse = 1;
        tick();
        bus_if.d_req = 0; bus_if.d_address = 32'h77777777; bus_if.d_writedata = 0;
        bus_if.d_write = 0;
        early = 0;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("ws_haddr%0d", k), bus_if.Haddress, 32'h20000040);
            chk($sformatf("ws_hw%0d", k), {bus_if.Hwrite, bus_if.Hsize}, 32'd3);
            chk($sformatf("ws_hwdata%0d", k), bus_if.Hwritedata, 32'hDEADBEEF);
            early |= bus_if.d_done;
            if (k == 5) begin
                bus_if.Hready = 1; bus_if.Hreaddata = 32'h12345678;
            end
            tick();
        end
        chk("ws_no_early_done", early, 0);
        chk("ws_ddone", bus_if.d_done, 1);
        chk("ws_dresp", bus_if.d_response, 1);
        chk("ws_drdata", bus_if.d_readdata, 32'h12345678);
        chk("ws_haddr_idle", bus_if.Haddress, 32'hFFFFFFFF);
        chk("ws_hwrite_idle", bus_if.Hwrite, 0);
        bus_if.Hready = 0; bus_if.Hresponse = 0;
        tick();
        chk("ws_ddone_end", bus_if.d_done, 0);

        // timeout: Hready held low
        bus_if.d_req = 1; bus_if.d_address = 32'h00000300;
        tick();
        bus_if.d_req = 0;
        early = 0;
        for (int k = 0; k < 254; k++) begin
            tick();
            early |= bus_if.d_done;
        end
        chk("to_no_early_done", early, 0);
        chk("to_haddr_held", bus_if.Haddress, 32'h00000300);
        tick();
        chk("to_ddone", bus_if.d_done, 1);
        chk("to_dresp", bus_if.d_response, 1);
        chk("to_drdata", bus_if.d_readdata, 0);
        chk("to_haddr_idle", bus_if.Haddress, 32'hFFFFFFFF);
        tick();

        // Hready coincident with the timeout edge completes normally
        bus_if.d_req = 1; bus_if.d_address = 32'h00000400;
        tick();
        bus_if.d_req = 0;
        for (int k = 0; k < 254; k++) tick();
        bus_if.Hready = 1; bus_if.Hreaddata = 32'h55AA55AA; bus_if.Hresponse = 0;
        tick();
        chk("toready_ddone", bus_if.d_done, 1);
        chk("toready_drdata", bus_if.d_readdata, 32'h55AA55AA);
        chk("toready_dresp", bus_if.d_response, 0);
        bus_if.Hready = 0;
        tick();

        // reset mid-BUSY
        bus_if.i_req = 1; bus_if.i_address = 32'h1FC00100;
        tick();
        bus_if.i_req = 0;
        tick(); tick(); tick();
        chk("rb_haddr_busy", bus_if.Haddress, 32'h1FC00100);
        Hreset = 0;
        #1;
        chk("rb_haddr_rst", bus_if.Haddress, 32'hFFFFFFFF);
        chk("rb_idone", bus_if.i_done, 0);
        chk("rb_rdata_rst", bus_if.i_readdata | bus_if.d_readdata, 0);
        tick();
        chk("rb_idone_hold", bus_if.i_done, 0);
        Hreset = 1;
        tick();
        bus_if.i_req = 1; bus_if.i_address = 32'h1FC00200;
        tick();
        chk("rb_new_haddr", bus_if.Haddress, 32'h1FC00200);
        bus_if.i_req = 0; bus_if.Hready = 1; bus_if.Hreaddata = 32'hCAFEF00D;
        tick();
        chk("rb_new_idone", bus_if.i_done, 1);
        chk("rb_new_rdata", bus_if.i_readdata, 32'hCAFEF00D);
        bus_if.Hready = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter sitting between the CPU's instruction-fetch port (I) and data-memory port (D) and the single master port of the system `bus`. It serialises requests, holds each transaction stable on the bus until `Hready`, and returns read data and response to the owning master. It also enforces fixed D-priority with an anti-starvation limit for I, and a watchdog timeout per transaction.

## Interface
- `STREAK_MAX`, 4 — consecutive D grants allowed while I is waiting before I is forced.
- `TIMEOUT`, 255 — BUSY cycles with `Hready`=0 before the transaction is aborted.
- `IDLE_ADDR`, 32'hFFFFFFFF — address driven when idle; decodes to no-device.

Ports:
- `Hclock` in 1 — clock; all state updates on the rising edge.
- `Hreset` in 1 — asynchronous, active-low reset.
- `i_req` in 1 — I request, level.
- `i_write` in 1 — I write enable.
- `i_size` in 1 — I access size, passed to bus `Hsize`.
- `i_address` in 32 — I address.
- `i_writedata` in 32 — I write data.
- `i_done` out 1 — one-cycle completion pulse to I.
- `i_readdata` out 32 — I read data, registered.
- `i_response` out 1 — I error flag, registered (1=error).
- `d_req`, `d_write`, `d_size`, `d_address`, `d_writedata`, `d_done`, `d_readdata`, `d_response` — D port, identical to the I port.
- `Hsize` out 1, `Hwrite` out 1, `Hwritedata` out 32, `Haddress` out 32 — bus master outputs, registered.
- `Hreaddata` in 32, `Hresponse` in 1, `Hready` in 1 — bus returns.

## Operation
- States: IDLE, BUSY, DONE. `owner` register (I/D) records the granted master.
- IDLE:
  - If neither `req` is high, stay in IDLE.
  - Otherwise select a winner:
    - D wins when only D requests.
    - I wins when only I requests.
    - When both request, D wins unless `streak`==`STREAK_MAX`, in which case I wins.
  - At the edge, latch the winner's address, write, size and writedata into the H* outputs, set `owner`, clear `tcnt`, and go to BUSY.
- BUSY:
  - H* outputs are held constant.
  - If `Hready`=1 at an edge: capture `Hreaddata` into `owner`'s readdata and `Hresponse` into `owner`'s response, then go to DONE.
  - Else if `tcnt`==`TIMEOUT`-1: capture readdata=0 and response=1, then go to DONE.
  - Else `tcnt`++.
- DONE:
  - `owner`'s done=1 for exactly this cycle; the other master's done=0.
  - H* outputs return to idle values: `Haddress`=`IDLE_ADDR`, `Hwrite`=0, `Hsize`=0, `Hwritedata`=0.
  - Requests are ignored in DONE. The next edge goes to IDLE.
  - A master that keeps `req` high after its done pulse is treated as issuing a new request in IDLE.
- Streak counter (3 bits, saturating at `STREAK_MAX`), updated at the grant edge:
  - D granted while `i_req`=1: `streak`++.
  - I granted, or D granted with `i_req`=0: `streak`=0.
- readdata/response of a master keep their value until that master's next completion. The non-owner's registers are never written.
- `Hwritedata` is passed unmodified. Size and byte-lane handling are the bus's job.

## Timing
- Reset (`Hreset`=0, asynchronous):
  - state=IDLE, `owner`=D, `streak`=0, `tcnt`=0.
  - All done=0, all readdata=0, all response=0.
  - `Haddress`=`IDLE_ADDR`, `Hwrite`=0, `Hsize`=0, `Hwritedata`=0.
- Reset mid-BUSY aborts silently: no done pulse is issued.
- Minimum latency, req sampled in IDLE (edge 0):
  - BUSY from edge 0.
  - `Hready` seen at edge 1 → DONE, done high during the cycle after edge 1.
  - Back to IDLE at edge 2.
  - Minimum of 3 cycles per transaction; back-to-back issue every 3 cycles.
- H* outputs change only at the IDLE→BUSY and BUSY→DONE edges.
- Timeout completion occurs at the edge where `tcnt`==`TIMEOUT`-1 and `Hready`=0, i.e. `TIMEOUT` BUSY cycles after the grant.
- `Hready`=1 at the same edge as the timeout condition counts as normal completion: bus data is captured.
- Master inputs are sampled only at the grant edge. Changes during BUSY/DONE have no effect.

## Test plan
- Single I read: `i_req`=1, `i_address`=32'h1FC00000, `Hready` high one cycle after grant with `Hreaddata`=32'h3C08BFC0 → `Haddress`=32'h1FC00000 in BUSY; `i_done` pulses once; `i_readdata`=32'h3C08BFC0, `i_response`=0; `d_done` stays 0.
- Simultaneous requests: both `req` high, I=32'h1FC00004, D=32'h00000010 → D granted first (`Haddress`=32'h00000010), then I in the next IDLE.
- Starvation: `d_req` and `i_req` held high continuously, immediate `Hready` → grant order D,D,D,D,I,D,D,D,D,I…
- Wait states: D write, `Hready` low for 5 BUSY cycles, then high → `Haddress`/`Hwrite`=1/`Hwritedata` stable for all 6 BUSY cycles; `d_done` pulses exactly once; `d_response` = `Hresponse`.
- Timeout: `Hready` held 0 → `d_done` after 255 BUSY cycles with `d_response`=1, `d_readdata`=0; `Haddress` returns to 32'hFFFFFFFF in DONE.
- Reset mid-BUSY: deassert `Hreset` during a wait-stated I read → outputs immediately at reset values, no `i_done`; after release, a new request completes normally.
